// File: rtl/id_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | id_hazard_ctrl: decode-stage redirect, rs forwarding, hazard stall,  |
// | nested EPC stack for traps and a stall watchdog.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module id_hazard_ctrl #(
    parameter int            DW        = 16,
    parameter int            RW        = 3,
    parameter int            EPC_DEPTH = 4,
    parameter logic [DW-1:0] EXC_VEC   = 16'h0002,
    parameter logic [DW-1:0] RST_VEC   = 16'h0000,
    parameter int            STALL_MAX = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_fd,
    input  logic [RW-1:0]                rs_fd,
    input  logic [RW-1:0]                rt_fd,
    input  logic                         uses_rs_fd,
    input  logic                         uses_rt_fd,
    input  logic                         branch_fd,
    input  logic [2:0]                   cond_fd,
    input  logic                         jump_fd,
    input  logic                         illegal_fd,
    input  logic                         rti_fd,
    input  logic [DW-1:0]                pcinc_fd,
    input  logic [DW-1:0]                target_fd,
    input  logic [DW-1:0]                rsdata_fd,
    input  logic                         ex_regwrite,
    input  logic                         ex_memread,
    input  logic [RW-1:0]                ex_rd,
    input  logic [DW-1:0]                ex_data,
    input  logic                         mem_regwrite,
    input  logic                         mem_memread,
    input  logic [RW-1:0]                mem_rd,
    input  logic [DW-1:0]                mem_data,
    input  logic                         wb_regwrite,
    input  logic [RW-1:0]                wb_rd,
    input  logic [DW-1:0]                wb_data,
    output logic                         stall_d,
    output logic                         bubble_dx,
    output logic                         redirect_df,
    output logic [DW-1:0]                redirect_pc,
    output logic                         flush_dx,
    output logic [DW-1:0]                rsfwd_dx,
    output logic [$clog2(EPC_DEPTH):0]   epc_depth,
    output logic                         err_d
);

    localparam int c_PW  = $clog2(EPC_DEPTH);
    localparam int c_WDW = $clog2(STALL_MAX + 1);

    logic [DW-1:0]    r_stack [EPC_DEPTH];
    logic [c_PW:0]    r_depth;
    logic [c_WDW-1:0] r_wd;
    logic             r_err;

    logic             w_valid;
    logic [DW-1:0]    w_fwd;
    logic             w_haz;
    logic             w_taken;
    logic             w_full;
    logic             w_empty;
    logic [DW-1:0]    w_top;
    logic             w_push;
    logic             w_pop;
    logic             w_rti_err;
    logic [c_WDW-1:0] w_wd_next;

    assign w_valid = valid_fd & ~rst;
    assign w_full  = (r_depth == (c_PW+1)'(EPC_DEPTH));
    assign w_empty = (r_depth == '0);
    assign w_top   = r_stack[c_PW'(r_depth - 1'b1)];

    // Youngest producer wins; loads in EX/MEM cannot forward and are caught as hazards.
    always_comb begin
        w_fwd = rsdata_fd;
        if (ex_regwrite && !ex_memread && ex_rd == rs_fd)
            w_fwd = ex_data;
        else if (mem_regwrite && !mem_memread && mem_rd == rs_fd)
            w_fwd = mem_data;
        else if (wb_regwrite && wb_rd == rs_fd)
            w_fwd = wb_data;
    end

    assign rsfwd_dx = w_fwd;

    assign w_haz = w_valid &
                   ((ex_memread & ex_regwrite &
                     ((uses_rs_fd & (ex_rd == rs_fd)) | (uses_rt_fd & (ex_rd == rt_fd)))) |
                    (branch_fd & mem_memread & mem_regwrite & (mem_rd == rs_fd)));

    always_comb begin
        w_taken = 1'b0;
        case (cond_fd)
            3'b000:  w_taken = (w_fwd == '0);
            3'b001:  w_taken = w_fwd[DW-1];
            3'b011:  w_taken = (w_fwd != '0);
            3'b100:  w_taken = ~w_fwd[DW-1];
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        stall_d     = 1'b0;
        bubble_dx   = 1'b0;
        redirect_df = 1'b0;
        redirect_pc = RST_VEC;
        flush_dx    = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_rti_err   = 1'b0;
        if (w_valid) begin
            if (illegal_fd) begin
                redirect_df = 1'b1;
                redirect_pc = EXC_VEC;
                flush_dx    = 1'b1;
                w_push      = 1'b1;
            end else if (rti_fd) begin
                redirect_df = 1'b1;
                redirect_pc = w_empty ? RST_VEC : w_top;
                w_pop       = ~w_empty;
                w_rti_err   = w_empty;
            end else if (w_haz) begin
                stall_d     = 1'b1;
                bubble_dx   = 1'b1;
            end else if (jump_fd || (branch_fd && w_taken)) begin
                redirect_df = 1'b1;
                redirect_pc = target_fd;
            end
        end
    end

    always_comb begin
        if (!stall_d)
            w_wd_next = '0;
        else if (r_wd == c_WDW'(STALL_MAX))
            w_wd_next = r_wd;
        else
            w_wd_next = r_wd + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < EPC_DEPTH; i++)
                r_stack[i] <= '0;
            r_depth <= '0;
            r_wd    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wd <= w_wd_next;
            if (w_push && !w_full) begin
                r_stack[r_depth[c_PW-1:0]] <= pcinc_fd;
                r_depth                    <= r_depth + 1'b1;
            end else if (w_pop) begin
                r_depth <= r_depth - 1'b1;
            end
            if ((w_push && w_full) || w_rti_err || (w_wd_next == c_WDW'(STALL_MAX)))
                r_err <= 1'b1;
        end
    end

    assign epc_depth = r_depth;
    assign err_d     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_id_hazard_ctrl: scenario tasks with a queue of expected controls. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_id_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        valid_fd;
    logic [2:0]  rs_fd, rt_fd;
    logic        uses_rs_fd, uses_rt_fd;
    logic        branch_fd;
    logic [2:0]  cond_fd;
    logic        jump_fd, illegal_fd, rti_fd;
    logic [15:0] pcinc_fd, target_fd, rsdata_fd;
    logic        ex_regwrite, ex_memread;
    logic [2:0]  ex_rd;
    logic [15:0] ex_data;
    logic        mem_regwrite, mem_memread;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        wb_regwrite;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        stall_d, bubble_dx, redirect_df, flush_dx;
    logic [15:0] redirect_pc, rsfwd_dx;
    logic [2:0]  epc_depth;
    logic        err_d;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic        redir;
        logic        flush;
        logic [15:0] pc;
    } ctl_t;

    ctl_t        exp_q [$];
    logic [15:0] fwd_q [$];
    logic [15:0] epc_model [$];
    int          checks = 0;
    int          errors = 0;

    id_hazard_ctrl dut (
        .clk(clk), .rst(rst), .valid_fd(valid_fd), .rs_fd(rs_fd), .rt_fd(rt_fd),
        .uses_rs_fd(uses_rs_fd), .uses_rt_fd(uses_rt_fd), .branch_fd(branch_fd),
        .cond_fd(cond_fd), .jump_fd(jump_fd), .illegal_fd(illegal_fd), .rti_fd(rti_fd),
        .pcinc_fd(pcinc_fd), .target_fd(target_fd), .rsdata_fd(rsdata_fd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .mem_data(mem_data), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_d(stall_d), .bubble_dx(bubble_dx), .redirect_df(redirect_df),
        .redirect_pc(redirect_pc), .flush_dx(flush_dx), .rsfwd_dx(rsfwd_dx),
        .epc_depth(epc_depth), .err_d(err_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        valid_fd = 0; rs_fd = 0; rt_fd = 0; uses_rs_fd = 0; uses_rt_fd = 0;
        branch_fd = 0; cond_fd = 0; jump_fd = 0; illegal_fd = 0; rti_fd = 0;
        pcinc_fd = 0; target_fd = 0; rsdata_fd = 0;
        ex_regwrite = 0; ex_memread = 0; ex_rd = 0; ex_data = 0;
        mem_regwrite = 0; mem_memread = 0; mem_rd = 0; mem_data = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    endtask

    // Every task starts and ends one time unit after a rising edge.
    task automatic do_reset();
        idle();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        epc_model.delete();
    endtask

    task automatic test_reset();
        ctl_t got, e;
        idle();
        rst = 1; valid_fd = 1; illegal_fd = 1; uses_rs_fd = 1;
        ex_memread = 1; ex_regwrite = 1;
        @(posedge clk); #1;
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        @(negedge clk);
        got = {stall_d, bubble_dx, redirect_df, flush_dx, redirect_pc};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL reset_ctl: got %h want %h", got, e); end
        checks++;
        if (epc_depth !== 3'd0 || err_d !== 1'b0) begin
            errors++; $display("FAIL reset_state: depth %0d err %b want 0 0", epc_depth, err_d);
        end
        @(posedge clk); #1;
        rst = 0;
        idle();
    endtask

    typedef struct packed {
        logic        exw, memw, wbw;
        logic [2:0]  cond;
        logic [15:0] exd, memd, wbd, rsd, fwd;
        logic        tk;
    } fv_t;

    task automatic test_forwarding();
        fv_t  tbl [6];
        ctl_t got, e;
        logic [15:0] ef;
        tbl = '{
            '{1'b1, 1'b0, 1'b1, 3'b001, 16'h8000, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 1'b1},
            '{1'b0, 1'b1, 1'b0, 3'b011, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 1'b1},
            '{1'b0, 1'b0, 1'b1, 3'b011, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 16'h0000, 1'b0},
            '{1'b0, 1'b0, 1'b0, 3'b100, 16'h0000, 16'h0000, 16'h0000, 16'h7fff, 16'h7fff, 1'b1},
            '{1'b1, 1'b0, 1'b0, 3'b010, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0},
            '{1'b0, 1'b1, 1'b1, 3'b000, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 16'h0005, 1'b0}
        };
        for (int i = 0; i < 6; i++) begin
            idle();
            valid_fd = 1; branch_fd = 1; uses_rs_fd = 1; rs_fd = 3'd2; target_fd = 16'h0100;
            cond_fd = tbl[i].cond; rsdata_fd = tbl[i].rsd;
            ex_regwrite = tbl[i].exw;  ex_rd = 3'd2;  ex_data = tbl[i].exd;
            mem_regwrite = tbl[i].memw; mem_rd = 3'd2; mem_data = tbl[i].memd;
            wb_regwrite = tbl[i].wbw;  wb_rd = 3'd2;  wb_data = tbl[i].wbd;
            exp_q.push_back('{1'b0, 1'b0, tbl[i].tk, 1'b0, 16'h0100});
            fwd_q.push_back(tbl[i].fwd);
            @(negedge clk);
            got = {stall_d, bubble_dx, redirect_df, flush_dx, redirect_pc};
            e = exp_q.pop_front();
            if (!e.redir) got.pc = e.pc;
            checks++;
            if (got !== e) begin errors++; $display("FAIL fwd_ctl[%0d]: got %h want %h", i, got, e); end
            ef = fwd_q.pop_front();
            checks++;
            if (rsfwd_dx !== ef) begin errors++; $display("FAIL fwd_val[%0d]: got %h want %h", i, rsfwd_dx, ef); end
            @(posedge clk); #1;
        end
        idle();
        valid_fd = 1; jump_fd = 1; target_fd = 16'h0abc;
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0abc});
        @(negedge clk);
        got = {stall_d, bubble_dx, redirect_df, flush_dx, redirect_pc};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL jump: got %h want %h", got, e); end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_load_use();
        ctl_t got, e;
        idle();
        valid_fd = 1; branch_fd = 1; uses_rs_fd = 1; rs_fd = 3'd3; cond_fd = 3'b000;
        target_fd = 16'h0200; rsdata_fd = 16'hffff;
        for (int s = 0; s < 3; s++) begin
            ex_memread = (s == 0); ex_regwrite = (s == 0); ex_rd = 3'd3;
            mem_memread = (s == 1); mem_regwrite = (s == 1); mem_rd = 3'd3;
            wb_regwrite = (s == 2); wb_rd = 3'd3; wb_data = 16'h0000;
            if (s < 2) exp_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
            else       exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0200});
            @(negedge clk);
            got = {stall_d, bubble_dx, redirect_df, flush_dx, redirect_pc};
            e = exp_q.pop_front();
            if (!e.redir) got.pc = e.pc;
            checks++;
            if (got !== e) begin errors++; $display("FAIL load_branch[%0d]: got %h want %h", s, got, e); end
            @(posedge clk); #1;
        end
        // Non-branch: rt load in EX stalls, rt load in MEM does not.
        for (int s = 0; s < 2; s++) begin
            idle();
            valid_fd = 1; uses_rt_fd = 1; rt_fd = 3'd5; rs_fd = 3'd1;
            ex_memread = (s == 0); ex_regwrite = (s == 0); ex_rd = 3'd5;
            mem_memread = (s == 1); mem_regwrite = (s == 1); mem_rd = 3'd5;
            exp_q.push_back('{s == 0, s == 0, 1'b0, 1'b0, 16'h0000});
            @(negedge clk);
            got = {stall_d, bubble_dx, redirect_df, flush_dx, redirect_pc};
            e = exp_q.pop_front();
            got.pc = e.pc;
            checks++;
            if (got !== e) begin errors++; $display("FAIL load_rt[%0d]: got %h want %h", s, got, e); end
            @(posedge clk); #1;
        end
        idle();
    endtask

    task automatic test_rti_empty();
        ctl_t got, e;
        do_reset();
        valid_fd = 1; rti_fd = 1; uses_rs_fd = 1; ex_memread = 1; ex_regwrite = 1;
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        @(negedge clk);
        got = {stall_d, bubble_dx, redirect_df, flush_dx, redirect_pc};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL rti_empty_ctl: got %h want %h", got, e); end
        @(posedge clk); #1;
        idle();
        checks++;
        if (err_d !== 1'b1 || epc_depth !== 3'd0) begin
            errors++; $display("FAIL rti_empty_state: err %b depth %0d want 1 0", err_d, epc_depth);
        end
    endtask

    task automatic test_nested_traps();
        ctl_t got, e;
        logic [15:0] pc;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            pc = 16'((i + 1) * 16);
            valid_fd = 1; illegal_fd = 1; pcinc_fd = pc;
            if (epc_model.size() < 4) epc_model.push_back(pc);
            exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 16'h0002});
            @(negedge clk);
            got = {stall_d, bubble_dx, redirect_df, flush_dx, redirect_pc};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL trap_ctl[%0d]: got %h want %h", i, got, e); end
            @(posedge clk); #1;
            checks++;
            if (epc_depth !== 3'(epc_model.size()) || err_d !== (i == 4)) begin
                errors++;
                $display("FAIL trap_state[%0d]: depth %0d err %b want %0d %b",
                         i, epc_depth, err_d, epc_model.size(), (i == 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            valid_fd = 1; rti_fd = 1;
            exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, epc_model.pop_back()});
            @(negedge clk);
            got = {stall_d, bubble_dx, redirect_df, flush_dx, redirect_pc};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin errors++; $display("FAIL rti_ctl[%0d]: got %h want %h", i, got, e); end
            @(posedge clk); #1;
            checks++;
            if (epc_depth !== 3'(3 - i)) begin
                errors++; $display("FAIL rti_depth[%0d]: got %0d want %0d", i, epc_depth, 3 - i);
            end
        end
        idle();
    endtask

    task automatic test_illegal_hazard();
        ctl_t got, e;
        do_reset();
        valid_fd = 1; illegal_fd = 1; pcinc_fd = 16'h0066; uses_rs_fd = 1; rs_fd = 3'd1;
        ex_memread = 1; ex_regwrite = 1; ex_rd = 3'd1;
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 16'h0002});
        @(negedge clk);
        got = {stall_d, bubble_dx, redirect_df, flush_dx, redirect_pc};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL illegal_haz: got %h want %h", got, e); end
        @(posedge clk); #1;
        idle();
        checks++;
        if (epc_depth !== 3'd1 || err_d !== 1'b0) begin
            errors++; $display("FAIL illegal_haz_state: depth %0d err %b want 1 0", epc_depth, err_d);
        end
    endtask

    task automatic test_watchdog();
        ctl_t got, e;
        do_reset();
        valid_fd = 1; uses_rt_fd = 1; rt_fd = 3'd4; ex_memread = 1; ex_regwrite = 1; ex_rd = 3'd4;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (stall_d !== 1'b1 || err_d !== (k >= 9)) begin
                errors++; $display("FAIL watchdog[%0d]: stall %b err %b want 1 %b", k, stall_d, err_d, (k >= 9));
            end
            @(posedge clk); #1;
        end
        rst = 1;
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        @(negedge clk);
        got = {stall_d, bubble_dx, redirect_df, flush_dx, redirect_pc};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL rst_mid_stall_ctl: got %h want %h", got, e); end
        @(posedge clk); #1;
        checks++;
        if (err_d !== 1'b0 || epc_depth !== 3'd0 || stall_d !== 1'b0) begin
            errors++; $display("FAIL rst_mid_stall_state: err %b depth %0d stall %b want 0 0 0", err_d, epc_depth, stall_d);
        end
        rst = 0;
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_rti_empty();
        test_nested_traps();
        test_illegal_hazard();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running want finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Parametrised decode-stage control block. It resolves branch and jump redirects in ID, forwards the branch source operand from EX, MEM and WB, and detects load-use and branch-after-load hazards.
- It keeps a nested exception-PC (EPC) stack for illegal-op traps and RTI returns.
- Generalises the single-EPC, 16-bit, fixed-forwarding decode control to configurable width, register count and trap nesting depth. Adds a stall watchdog.
- Sits between the IF/ID and ID/EX pipeline registers. Drives fetch redirect and pipeline stall/bubble/flush.

Parameters:
- DW, 16, datapath and PC width
- RW, 3, register address width (2^RW registers)
- EPC_DEPTH, 4, EPC stack entries (power of 2, >=2)
- EXC_VEC, 16'h0002, trap target PC (DW bits)
- RST_VEC, 16'h0000, RTI target when the stack is empty
- STALL_MAX, 8, consecutive stall cycles before watchdog error

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_fd  in  1  IF/ID holds a real instruction
- rs_fd, rt_fd  in  RW  source register addresses
- uses_rs_fd, uses_rt_fd  in  1  instruction reads rs / rt
- branch_fd  in  1  conditional branch on rs
- cond_fd  in  3  branch condition code
- jump_fd  in  1  unconditional jump
- illegal_fd  in  1  illegal opcode
- rti_fd  in  1  return from trap
- pcinc_fd  in  DW  PC+2 of the instruction
- target_fd  in  DW  precomputed branch/jump target
- rsdata_fd  in  DW  register file read of rs
- ex_regwrite, ex_memread  in  1  ID/EX control
- ex_rd  in  RW  ID/EX destination register
- ex_data  in  DW  ID/EX ALU result
- mem_regwrite, mem_memread  in  1  EX/MEM control
- mem_rd  in  RW  EX/MEM destination register
- mem_data  in  DW  EX/MEM ALU result
- wb_regwrite  in  1  MEM/WB control
- wb_rd  in  RW  MEM/WB destination register
- wb_data  in  DW  MEM/WB writeback data
- stall_d  out  1  hold PC and IF/ID
- bubble_dx  out  1  force NOP into ID/EX
- redirect_df  out  1  load redirect_pc into PC; flush IF/ID
- redirect_pc  out  DW  new PC
- flush_dx  out  1  squash the ID/EX slot (trap)
- rsfwd_dx  out  DW  forwarded rs value
- epc_depth  out  clog2(EPC_DEPTH)+1  live stack entries
- err_d  out  1  sticky error

Behaviour:
- All state resets synchronously on rst:
  - EPC stack zeroed, depth=0, watchdog=0, err_d=0.
  - Combinational outputs are evaluated with valid_fd forced low during rst: all 0, redirect_pc=RST_VEC.
- Forwarding of rsfwd_dx, first match wins; register 0 is not special:
  - ex_regwrite & ~ex_memread & ex_rd==rs_fd → ex_data
  - else mem_regwrite & ~mem_memread & mem_rd==rs_fd → mem_data
  - else wb_regwrite & wb_rd==rs_fd → wb_data
  - else rsdata_fd
- Hazard (haz), only when valid_fd:
  - (ex_memread & ex_regwrite & ex_rd matches a used source), or
  - (branch_fd & mem_memread & mem_regwrite & mem_rd==rs_fd).
  - A branch therefore waits 2 cycles behind a load in EX and 1 cycle behind a load in MEM.
- Branch taken on rsfwd_dx:
  - 000: ==0
  - 001: bit[DW-1]=1
  - 011: !=0
  - 100: bit[DW-1]=0
  - any other code: never taken
- Priority, combinational within the cycle:
  - illegal_fd: redirect_df=1, redirect_pc=EXC_VEC, flush_dx=1, no stall. Illegal overrides a hazard.
  - rti_fd (not illegal): redirect to the stack top. If the stack is empty, redirect to RST_VEC and set err_d. rti waits on no hazard.
  - haz: stall_d=1, bubble_dx=1, redirect_df=0.
  - jump_fd: redirect to target_fd.
  - branch_fd & taken: redirect to target_fd.
- Stack update at the clock edge, only when valid_fd & ~rst:
  - Illegal pushes pcinc_fd. If full, the push is dropped, the contents are unchanged and err_d is set; the redirect still occurs.
  - rti pops, with no underflow below 0.
- Watchdog:
  - Counts consecutive stall_d cycles, saturating at STALL_MAX; cleared on any non-stall cycle.
  - On reaching STALL_MAX, err_d is set.
- err_d is sticky until rst.

Test Plan:
- Load r3 in EX, then branch on r3 (cond 000) in ID: stall_d=1 for 2 cycles, then with wb_data=0 redirect_df=1 and redirect_pc=target_fd.
- ALU writes r2=16'h8000 in EX, branch cond 001 on r2: no stall, rsfwd_dx=16'h8000, taken same cycle. With EX and WB both writing r2, the EX value wins.
- Five nested illegals with EPC_DEPTH=4 at pcinc 0x10/0x20/0x30/0x40/0x50: each redirects to 0x0002, and err_d=1 after the 5th. Four RTIs then return 0x40, 0x30, 0x20, 0x10.
- RTI with an empty stack: redirect_pc=RST_VEC, err_d=1, epc_depth stays 0.
- Illegal coincident with a load-use hazard: redirect to 0x0002, stall_d=0, flush_dx=1.
- Hazard held for 8 cycles: err_d rises at the 8th. Assert rst mid-stall: next cycle all outputs 0, epc_depth=0, err_d=0.
